// File: rtl/cmd_frame_initiator.sv
// Host-side UART command initiator: serialises one request into a command frame, then assembles the response word.
// Define CMD_FRAME_INITIATOR_TIMEOUT_EN to build the WAIT_RSP timeout path; otherwise RSP_ERR is tied 0.
module cmd_frame_initiator #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR           = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VLD,
    output logic                     REQ_RDY,
    input  logic [1:0]               REQ_CMD,
    input  logic [ADDR-1:0]          REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]    REQ_DATA,
    input  logic [DATA_WIDTH-1:0]    REQ_OPB,
    input  logic [3:0]               REQ_FUN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_RDY,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic                     RSP_VLD,
    output logic [ALU_OUT_WIDTH-1:0] RSP_DATA,
    output logic                     RSP_ERR,
    output logic                     BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD_RF_WR,
        CMD_RF_RD,
        CMD_ALU_OP,
        CMD_ALU_NOP
    } cmd_t;

    localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] HDR_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] HDR_NOP = DATA_WIDTH'(8'hDD);

    state_t                   state_q, state_d;
    cmd_t                     cmd_q, cmd_d;
    logic [ADDR-1:0]          addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [DATA_WIDTH-1:0]    opb_q, opb_d;
    logic [3:0]               fun_q, fun_d;
    logic [1:0]               idx_q, idx_d;
    logic                     rx_cnt_q, rx_cnt_d;
    logic [DATA_WIDTH-1:0]    rx_lo_q, rx_lo_d;
    logic [DATA_WIDTH-1:0]    rx_hi_q, rx_hi_d;
    logic [ALU_OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [DATA_WIDTH-1:0]    frame_byte;
    logic [1:0]               last_idx;
    logic                     rx_done;

`ifdef CMD_FRAME_INITIATOR_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        frame_byte = '0;
        last_idx   = 2'd1;
        unique case (cmd_q)
            CMD_RF_WR: begin
                last_idx = 2'd2;
                case (idx_q)
                    2'd0:    frame_byte = HDR_WR;
                    2'd1:    frame_byte = DATA_WIDTH'(addr_q);
                    default: frame_byte = data_q;
                endcase
            end
            CMD_RF_RD: begin
                frame_byte = (idx_q == 2'd0) ? HDR_RD : DATA_WIDTH'(addr_q);
            end
            CMD_ALU_OP: begin
                last_idx = 2'd3;
                case (idx_q)
                    2'd0:    frame_byte = HDR_OP;
                    2'd1:    frame_byte = data_q;
                    2'd2:    frame_byte = opb_q;
                    default: frame_byte = DATA_WIDTH'(fun_q);
                endcase
            end
            default: begin
                frame_byte = (idx_q == 2'd0) ? HDR_NOP : DATA_WIDTH'(fun_q);
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        data_d     = data_q;
        opb_d      = opb_q;
        fun_d      = fun_q;
        idx_d      = idx_q;
        rx_cnt_d   = rx_cnt_q;
        rx_lo_d    = rx_lo_q;
        rx_hi_d    = rx_hi_q;
        rsp_data_d = rsp_data_q;
        rx_done    = 1'b0;
`ifdef CMD_FRAME_INITIATOR_TIMEOUT_EN
        timer_d    = timer_q;
        rsp_err_d  = rsp_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (REQ_VLD) begin
                    cmd_d   = cmd_t'(REQ_CMD);
                    addr_d  = REQ_ADDR;
                    data_d  = REQ_DATA;
                    opb_d   = REQ_OPB;
                    fun_d   = REQ_FUN;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (TX_RDY) begin
                    if (idx_q == last_idx) begin
                        if (cmd_q == CMD_RF_WR) begin
                            state_d    = ST_DONE;
                            rsp_data_d = '0;
`ifdef CMD_FRAME_INITIATOR_TIMEOUT_EN
                            rsp_err_d  = 1'b0;
`endif
                        end else begin
                            state_d  = ST_WAIT_RSP;
                            rx_cnt_d = 1'b0;
                            rx_lo_d  = '0;
                            rx_hi_d  = '0;
`ifdef CMD_FRAME_INITIATOR_TIMEOUT_EN
                            timer_d  = '0;
`endif
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_WAIT_RSP: begin
                // A byte arriving on the expiry cycle is captured before the timeout is judged.
                if (RX_D_VLD) begin
                    if (!rx_cnt_q) begin
                        rx_lo_d  = RX_P_DATA;
                        rx_cnt_d = 1'b1;
                        rx_done  = (cmd_q == CMD_RF_RD);
                    end else begin
                        rx_hi_d = RX_P_DATA;
                        rx_done = 1'b1;
                    end
                end
                if (rx_done) begin
                    state_d    = ST_DONE;
                    rsp_data_d = ALU_OUT_WIDTH'({rx_hi_d, rx_lo_d});
`ifdef CMD_FRAME_INITIATOR_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = ST_DONE;
                    rsp_data_d = ALU_OUT_WIDTH'({rx_hi_d, rx_lo_d});
                    rsp_err_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_RF_WR;
            addr_q     <= '0;
            data_q     <= '0;
            opb_q      <= '0;
            fun_q      <= '0;
            idx_q      <= '0;
            rx_cnt_q   <= 1'b0;
            rx_lo_q    <= '0;
            rx_hi_q    <= '0;
            rsp_data_q <= '0;
`ifdef CMD_FRAME_INITIATOR_TIMEOUT_EN
            timer_q    <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            opb_q      <= opb_d;
            fun_q      <= fun_d;
            idx_q      <= idx_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_lo_q    <= rx_lo_d;
            rx_hi_q    <= rx_hi_d;
            rsp_data_q <= rsp_data_d;
`ifdef CMD_FRAME_INITIATOR_TIMEOUT_EN
            timer_q    <= timer_d;
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    assign REQ_RDY   = (state_q == ST_IDLE);
    assign BUSY      = (state_q != ST_IDLE);
    assign TX_D_VLD  = (state_q == ST_SEND);
    assign TX_P_DATA = TX_D_VLD ? frame_byte : '0;
    assign RSP_VLD   = (state_q == ST_DONE);
    assign RSP_DATA  = rsp_data_q;
`ifdef CMD_FRAME_INITIATOR_TIMEOUT_EN
    assign RSP_ERR   = rsp_err_q;
`else
    assign RSP_ERR   = 1'b0;
`endif

endmodule

// File: doc/cmd_frame_initiator.md
Name: cmd_frame_initiator

Overview:
- Host-side command initiator for the UART register/ALU command protocol, serving test and loopback harnesses.
- Accepts one request at a time and serialises it into frame bytes toward a UART TX: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands.
- Then collects the response bytes from a UART RX and returns one assembled response word.

Parameters:
DATA_WIDTH, 8, frame byte width
ADDR, 4, register-file address width, zero-extended into the address byte
ALU_OUT_WIDTH, 16, response word width (two bytes)
TIMEOUT_CYCLES, 4096, max CLK cycles spent in WAIT_RSP before error

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-low
REQ_VLD  in  1  request valid
REQ_RDY  out  1  request ready; high only in IDLE
REQ_CMD  in  2  0=RF_WR, 1=RF_RD, 2=ALU_OP, 3=ALU_NOP
REQ_ADDR  in  ADDR  register address (WR/RD)
REQ_DATA  in  DATA_WIDTH  write data (WR) / operand A (ALU_OP)
REQ_OPB  in  DATA_WIDTH  operand B (ALU_OP)
REQ_FUN  in  4  ALU function (ALU_OP/ALU_NOP), zero-extended into byte
TX_P_DATA  out  DATA_WIDTH  byte to UART TX
TX_D_VLD  out  1  byte valid
TX_RDY  in  1  UART TX accepts byte this cycle
RX_P_DATA  in  DATA_WIDTH  byte from UART RX
RX_D_VLD  in  1  one-cycle strobe, RX byte valid
RSP_VLD  out  1  one-cycle response strobe
RSP_DATA  out  ALU_OUT_WIDTH  assembled response
RSP_ERR  out  1  timeout flag, qualified by RSP_VLD
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0 except REQ_RDY=1; state IDLE; byte index, RX count, timer and latched fields 0.
- States: IDLE, SEND, WAIT_RSP, DONE.
- IDLE:
  - On REQ_VLD&&REQ_RDY, latch all REQ_* fields, clear byte index, go to SEND.
  - REQ_* are ignored in all other states.
- SEND frame sequences (frame = byte sequence per command, index 0 first):
  - RF_WR: AA, {0,addr}, data
  - RF_RD: BB, {0,addr}
  - ALU_OP: CC, A, B, {0,fun}
  - ALU_NOP: DD, {0,fun}
- SEND handshake:
  - TX_D_VLD=1 throughout SEND.
  - TX_P_DATA = frame byte at the current index, held stable until a cycle with TX_RDY=1.
  - The byte transfers on that edge and the index increments.
- After the last byte transfers:
  - RF_WR goes to DONE with RSP_DATA=0 (no response expected).
  - All other commands go to WAIT_RSP with RX count and timer cleared.
- Throughput: with TX_RDY tied 1, one byte per cycle. First byte presented the cycle after request acceptance.
- WAIT_RSP:
  - Each RX_D_VLD cycle captures RX_P_DATA.
  - RF_RD expects 1 byte: RSP_DATA={8'h00,byte}.
  - ALU commands expect 2 bytes, LSB first: byte0 -> RSP_DATA[7:0], byte1 -> RSP_DATA[15:8].
  - When the last expected byte is captured, go to DONE.
- Timeout: the timer increments every WAIT_RSP cycle. On reaching TIMEOUT_CYCLES-1 with bytes still outstanding, go to DONE with RSP_ERR=1 and RSP_DATA holding the partially captured bytes (uncaptured bytes 0).
- Simultaneous RX_D_VLD and timer expiry: the byte is captured first. If that completes the response, RSP_ERR=0.
- DONE:
  - RSP_VLD=1 for exactly one cycle.
  - RSP_DATA and RSP_ERR are registered and held until the next DONE.
  - Then go to IDLE.
- Earliest next request: accepted the cycle after DONE.
- RX_D_VLD outside WAIT_RSP: the byte is discarded with no state change.
- Reset mid-operation: frame abandoned immediately, all reset values restored, no RSP_VLD issued.

Optional Feature:
CMD_FRAME_INITIATOR_TIMEOUT_EN
- Defined: timer and timeout path implemented as specified.
- Undefined: no timer; WAIT_RSP waits indefinitely for the expected byte count; RSP_ERR tied 0.

Test Plan:
- RF_WR addr=5, data=0x3C, TX_RDY=1 -> TX bytes AA,05,3C on 3 consecutive cycles; RSP_VLD=1 one cycle later with RSP_DATA=0x0000, RSP_ERR=0.
- RF_RD addr=2; RX returns 0x7E after 10 cycles -> TX bytes BB,02; RSP_DATA=0x007E, RSP_ERR=0.
- ALU_OP A=0x12, B=0x34, fun=0 -> TX CC,12,34,00; RX bytes 0x46 then 0x00 -> RSP_DATA=0x0046.
- ALU_NOP fun=2 with TX_RDY low 3 cycles per byte -> DD held stable 3 cycles, then 02; TX_P_DATA unchanged while TX_RDY=0.
- ALU_NOP, RX sends only 0xAB (macro defined) -> after TIMEOUT_CYCLES: RSP_VLD=1, RSP_ERR=1, RSP_DATA=0x00AB; REQ_RDY=1 on the next cycle.
- RST asserted mid-SEND of ALU_OP, byte index 2 -> TX_D_VLD=0 and REQ_RDY=1 immediately; stray RX bytes after release ignored; no RSP_VLD.
